// File: rtl/df_serial_add_ctrl_pkg.sv
// df_serial_add_ctrl_pkg: shared state encodings and counter sizing for the serial add units
`ifndef DF_SERIAL_ADD_CTRL_PKG_SV
`define DF_SERIAL_ADD_CTRL_PKG_SV
package df_serial_add_ctrl_pkg;
  localparam logic [1:0] DF_SA_IDLE = 2'd0;
  localparam logic [1:0] DF_SA_RUN  = 2'd1;
  localparam logic [1:0] DF_SA_DONE = 2'd2;
  typedef enum logic [1:0] {
    S_IDLE = DF_SA_IDLE,
    S_RUN  = DF_SA_RUN,
    S_DONE = DF_SA_DONE
  } df_sa_state_t;
  function automatic int df_clog2(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage
`endif

// File: rtl/df_fulladder.sv
// df_fulladder: combinational full adder built from two half adders
module df_fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s1, c1, c2;
  df_halfadder u_ha0 (.x(a), .y(b), .s(s1), .c(c1));
  df_halfadder u_ha1 (.x(s1), .y(ci), .s(s), .c(c2));
  assign co = c1 | c2;
endmodule

// File: rtl/df_halfadder.sv
// df_halfadder: one-bit half adder
module df_halfadder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

// File: rtl/df_serial_add_ctrl.sv
// df_serial_add_ctrl: bit-serial add/subtract sequencer with valid/ready operand and result handshakes
module df_serial_add_ctrl
  import df_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int CW = df_clog2(WIDTH);
  df_sa_state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sa, sb;
  logic carry, fs, fc;
  df_fulladder u_fa (.a(sa[0]), .b(sb[0]), .ci(carry), .s(fs), .co(fc));
  assign in_ready  = state == S_IDLE;
  assign out_valid = state == S_DONE;
  assign busy      = state != S_IDLE;
  // subtraction is a + ~b + 1, the +1 entering through the preset carry
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      sa    <= '0;
      sb    <= '0;
      sum   <= '0;
      carry <= 1'b0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else
      case (state)
        S_IDLE: if (in_valid) begin
          sa    <= a;
          sb    <= sub ? ~b : b;
          carry <= sub;
          cnt   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          sum   <= {fs, sum[WIDTH-1:1]};
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= fc;
          if (cnt == CW'(WIDTH - 1)) begin
            cout  <= fc;
            ovf   <= fc ^ carry;
            state <= S_DONE;
          end else
            cnt <= cnt + CW'(1);
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_df_serial_add_ctrl.sv
// tb_df_serial_add_ctrl: scoreboard bench for the serial add/subtract sequencer at WIDTH=8
module tb_df_serial_add_ctrl;
  localparam int W = 8;
  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } res_t;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, busy;
  logic [W-1:0] a, b, sum;
  res_t exp_q[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  df_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W-1:0] yy;
    logic [W:0] full;
    res_t r;
    yy = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
    r.s = full[W-1:0];
    r.c = full[W];
    r.v = (x[W-1] == yy[W-1]) && (r.s[W-1] != x[W-1]);
    return r;
  endfunction
  always @(negedge clk)
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      res_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sum=%0h with nothing expected", sum);
      end else begin
        e = exp_q.pop_front();
        chk("sum", sum, e.s);
        chk("cout", cout, e.c);
        chk("ovf", ovf, e.v);
      end
    end
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) fail("in_ready_timeout");
  endtask
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input res_t e,
                        output int lat);
    wait_ready();
    a = x; b = y; sub = s; in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) fail("out_valid_timeout");
  endtask
  task automatic drain();
    int n = 0;
    while (out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (out_valid) fail("drain_timeout");
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, n;
    time t, prev;
    res_t e;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    run_op(8'h35, 8'h4A, 1'b0, '{8'h7F, 1'b0, 1'b0}, lat);
    chk("latency", lat, 9);
    drain();
    run_op(8'h7F, 8'h01, 1'b0, '{8'h80, 1'b0, 1'b1}, lat); drain();
    run_op(8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0}, lat); drain();
    run_op(8'h10, 8'h20, 1'b1, '{8'hF0, 1'b0, 1'b0}, lat); drain();
    run_op(8'h80, 8'h01, 1'b1, '{8'h7F, 1'b1, 1'b1}, lat); drain();
    out_ready = 1'b0;
    run_op(8'h12, 8'h34, 1'b0, '{8'h46, 1'b0, 1'b0}, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; a = 8'hAA; b = 8'h55;
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_sum", sum, 8'h46);
      chk("bp_cout", cout, 0);
      chk("bp_ovf", ovf, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_queue", exp_q.size(), 0);
    wait_ready();
    a = 8'h55; b = 8'h22; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (12) @(posedge clk);
    #1 chk("mid_rst_no_result", out_valid, 0);
    run_op(8'h01, 8'h01, 1'b0, '{8'h02, 1'b0, 1'b0}, lat); drain();
    prev = 0;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom); in_valid = 1'b1;
      e = model(a, b, sub);
      exp_q.push_back(e);
      wait_ready();
      @(posedge clk);
      t = $time;
      if (i > 0) chk("b2b_spacing", 64'((t - prev) / 10), W + 2);
      prev = t;
      #1;
    end
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("final_queue", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/df_serial_add_ctrl.md
Name: df_serial_add_ctrl

Overview:
Bit-serial add/subtract sequencer for the digital filter datapath. It loads two WIDTH-bit operands and feeds them LSB-first through one full-adder cell (two df_halfadder instances plus a carry flop), one bit per clock. The result is presented on a valid/ready output handshake. It trades WIDTH cycles of latency for a one-bit adder area, and sits between the filter tap sequencer and the accumulator register.

Parameters:
WIDTH, 16, operand and result width in bits; legal range 2..64.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  operand A (two's complement)
b  input  WIDTH  operand B (two's complement)
sub  input  1  0: a+b, 1: a-b; sampled with operands
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB (sub mode: 1 = no borrow)
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: rst is sampled on the clock edge only and has priority over everything else.
  - Resets state to IDLE, bit counter to 0, operand/sum shift registers to 0, and carry flop to 0.
  - Output values during reset: in_ready=1 (after reset), out_valid=0, sum=0, cout=0, ovf=0, busy=0.
- States: IDLE, RUN, DONE (encoding from shared defines).
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready:
    - Load A into shift register sa.
    - Load B into shift register sb: B if sub=0, ~B if sub=1.
    - Carry flop := sub.
    - Bit counter := 0.
    - Go to RUN.
  - Inputs are ignored otherwise.
- RUN: each edge processes bit i=counter.
  - Full adder on (sa[0], sb[0], carry) gives bit s and carry c.
  - Sum shift register shifts right with s inserted at the MSB.
  - sa and sb shift right.
  - carry := c.
  - When i=WIDTH-1:
    - Also latch cout := c.
    - Latch ovf := c XOR (carry-in of this bit).
    - Go to DONE.
  - Otherwise counter := i+1.
- Latency: out_valid is high in the cycle after the WIDTH-th RUN edge. That is WIDTH+1 edges after the accepting edge, including the accept edge.
- DONE:
  - out_valid=1.
  - sum, cout and ovf are stable and held while out_ready=0 (indefinite backpressure).
  - On out_valid&out_ready, go to IDLE.
  - No same-cycle re-accept: in_ready stays 0 in DONE.
- Result hold: sum, cout and ovf keep their last value in IDLE until the next accepted operation overwrites them.
  - During RUN, sum shows the partial shift contents; consumers use it only when out_valid=1.
- Arithmetic is modulo 2^WIDTH. The final carry is discarded from sum and reported on cout.
- Reset mid-RUN or mid-DONE: the operation is discarded with no output handshake. The next cycle is IDLE with out_valid=0.
- in_valid asserted during RUN/DONE: ignored. The upstream must hold its operands until in_ready.

Decomposition:
- Shared defines file (guarded include, df_ prefix):
  - FSM state encodings DF_SA_IDLE, DF_SA_RUN, DF_SA_DONE (2 bits).
  - Counter width function/macro clog2(WIDTH).
- Sub-module df_fulladder: two df_halfadder instances plus an OR gate for the carry. It is combinational and reusable by other serial units in the filter.
- The controller holds the FSM, counter, shift registers and carry flop.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, sub=0 -> sum=0x7F, cout=0, ovf=0. out_valid rises exactly 9 edges after the accept edge.
- a=0x7F, b=0x01, sub=0 -> sum=0x80, cout=0, ovf=1. Then a=0xFF, b=0x01 -> sum=0x00, cout=1, ovf=0.
- a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, ovf=1, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout and ovf are constant. in_ready=0, and in_valid pulses are ignored. Release -> IDLE next cycle with in_ready=1.
- Reset after 3 RUN edges -> the next cycle shows IDLE, in_ready=1, out_valid=0, sum=0, and no result handshake. A fresh add of 0x01+0x01 then gives 0x02.
- Back-to-back: in_valid held high with out_ready=1 -> each accept is spaced WIDTH+2 edges apart. Results match a reference model for 1000 random operand/sub triples.
